// File: rtl/router_in_port.sv
// Router input port: reassembles 4-byte MSB-first serial packets into a 2-entry buffer and routes the head packet.
// Optional protocol-error counter is enabled by defining ROUTER_IN_ERRCNT_EN.
module router_in_port #(
    parameter int NPORTS      = 4,
    parameter int LOCAL_BASE  = 0,
    parameter int LOCAL_CNT   = 3,
    parameter int UPLINK_PORT = 3
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              put,
    input  logic [7:0]        payload,
    output logic              free,
    output logic [NPORTS-1:0] out_req,
    output logic [31:0]       out_pkt,
    input  logic              out_grant,
    output logic [7:0]        err_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    localparam logic [3:0] LBASE = 4'(LOCAL_BASE);
    localparam logic [4:0] LCNT  = 5'(LOCAL_CNT);

    logic [0:0]  state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic        ignore_q, ignore_d;
    logic [31:0] buf_q [2];
    logic        w_ptr_q, r_ptr_q;
    logic [1:0]  count_q, count_d;

    logic        push, pop, start, put_err;
    logic        head_vld, is_local;
    logic [3:0]  dest, off;

    assign free = (state_q == S_IDLE) && (count_q < 2'd2);

    // A burst that arrives while full is ignored in its entirety, even if a slot frees mid-burst.
    assign put_err = put && (state_q == S_IDLE) && !free && !ignore_q;
    assign start   = put && (state_q == S_IDLE) && free && !ignore_q;
    assign ignore_d = put ? (ignore_q || put_err) : 1'b0;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RECV;
                    shift_d    = {16'h0000, payload};
                    byte_cnt_d = 2'd1;
                end
            end
            S_RECV: begin
                if (put) begin
                    shift_d    = {shift_q[15:0], payload};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d    = S_IDLE;
                    byte_cnt_d = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop = out_grant && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'h0;
            ignore_q   <= 1'b0;
            w_ptr_q    <= 1'b0;
            r_ptr_q    <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            ignore_q   <= ignore_d;
            count_q    <= count_d;
            if (push) w_ptr_q <= ~w_ptr_q;
            if (pop)  r_ptr_q <= ~r_ptr_q;
        end
    end

    // Packet storage carries no reset; the head is masked by count on the output.
    always_ff @(posedge clk) begin
        if (push) buf_q[w_ptr_q] <= {shift_q, payload};
    end

    assign head_vld = (count_q != 2'd0);
    assign out_pkt  = head_vld ? buf_q[r_ptr_q] : 32'h0;

    assign dest     = out_pkt[27:24];
    assign off      = dest - LBASE;
    assign is_local = ({1'b0, off} < LCNT);

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_req
        assign out_req[gi] = head_vld && (is_local ? (off == 4'(gi)) : (gi == UPLINK_PORT));
    end

`ifdef ROUTER_IN_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic       abort_evt;

    // Abort needs put low and put_err needs put high, so at most one event per cycle.
    assign abort_evt = (state_q == S_RECV) && !put;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            err_cnt_q <= 8'h00;
        end else if ((abort_evt || put_err) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: doc/router_in_port.md
# router_in_port

Router-side input port that sits directly downstream of a node's endpoint serializer. It accepts the 4-byte MSB-first serial stream on the put/free/payload link and reassembles 32-bit packets into a 2-entry packet buffer. It decodes each head packet's destination into a one-hot output-port request for the router crossbar and pops the packet when the crossbar grants it.

## Interface
Parameters:
- NPORTS, 4, number of router output ports; width of `out_req`.
- LOCAL_BASE, 0, lowest node ID attached locally to this router.
- LOCAL_CNT, 3, number of local node IDs; local IDs map to ports 0..LOCAL_CNT-1.
- UPLINK_PORT, 3, output port used for every non-local destination.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_b, input, 1, reset; synchronous and active-high despite the `_b` suffix.
- put, input, 1, byte valid from the node; high for exactly 4 consecutive cycles per packet.
- payload, input, 8, serial byte; the first byte is pkt[31:24], the last is pkt[7:0].
- free, output, 1, port can accept a complete new packet.
- out_req, output, NPORTS, one-hot crossbar request for the head packet; all zero when the buffer is empty.
- out_pkt, output, 32, head packet; valid whenever `out_req` is nonzero.
- out_grant, input, 1, crossbar accepts the head packet this cycle.
- err_cnt, output, 8, protocol-error count (see Configuration).

## Operation
- Packet format: [31:28] src, [27:24] dest, [23:0] data.
- The receive FSM has two states, IDLE and RECV.
  - IDLE to RECV: `put` is high while `free` is high. Byte 0 is captured into pkt[31:24] and `byte_cnt` is set to 1.
  - RECV: each cycle with `put` high, the FSM shifts the byte in and increments `byte_cnt` (2 bits).
  - On the 4th byte, the assembled word is pushed into the buffer and the FSM returns to IDLE.
  - RECV with `put` low before the 4th byte is an abort: the partial word is discarded, the FSM returns to IDLE, and no push occurs.
- `put` high in IDLE while `free` is low is a protocol error. The bytes are ignored, the FSM stays in IDLE, and the error is not re-flagged until `put` falls.
- `free` = (state == IDLE) && (count < 2). It is combinational from registered state. The buffer slot is committed once RECV begins, so the 4th-byte push never overflows.
- Buffer: 2-entry circular packet FIFO with 1-bit `w_ptr`/`r_ptr` and a 2-bit count (0..2). Pointers wrap 1 to 0.
- Route decode on the head packet:
  - If dest is in [LOCAL_BASE, LOCAL_BASE+LOCAL_CNT-1], `out_req[dest-LOCAL_BASE]` = 1.
  - Otherwise, `out_req[UPLINK_PORT]` = 1.
  - Decode width is 4 bits and the subtraction is 4-bit unsigned.
- Pop: `out_grant` high while count > 0 advances `r_ptr` and decrements count. `out_grant` while empty is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance. At count == 1 the pushed packet becomes the head on the next cycle.

## Timing
- Reset (rst_b = 1 at an edge):
  - State becomes IDLE; `byte_cnt`, pointers and count are 0; `err_cnt` is 0.
  - Outputs after the edge: `free` = 1, `out_req` = 0, `out_pkt` = 32'h0.
  - Reset mid-RECV discards the partial packet. Reset also discards any buffered packets.
- Latency: with the 4th byte sampled at edge N, `out_req`/`out_pkt` are valid in the cycle after edge N (4 cycles after the first `put`).
- `free` drops in the cycle after edge N0, where edge N0 samples byte 0. `free` rises again in the cycle after the 4th-byte edge if count < 2.
- A sender that sees `free` high in cycle t and drives `put` in cycle t+1 is accepted, because the FSM is still in IDLE with `free` high.
- The full-to-free transition is combinational on the pop edge: after a grant at edge G with count 2, `free` is high in the cycle after G.
- Back-to-back packets: a new packet may start in the cycle immediately after the 4th byte, provided `free` is high in that cycle.

## Configuration
- ROUTER_IN_ERRCNT_EN defined:
  - `err_cnt` is an 8-bit counter that saturates at 8'hFF.
  - It increments by 1 per abort event and by 1 per `put`-rising-while-not-free event.
  - If both events occur in the same cycle, it increments by 1.
- ROUTER_IN_ERRCNT_EN undefined: `err_cnt` is tied to 8'h00 and the counter logic is absent. Aborts and ignored puts behave identically to the defined case.

## Test plan
- Reset, then send bytes 8'h12, 8'h34, 8'h56, 8'h78 (dest 2) → `out_pkt` = 32'h12345678 and `out_req` = 4'b0100 four cycles after the first `put`; `free` returns to 1.
- Send dest 9 (32'h19ABCDEF) → `out_req` = 4'b1000 (UPLINK_PORT); assert `out_grant` for one cycle → `out_req` = 0 the next cycle.
- Send two packets with no grant → `free` = 0 after the second completes. A third `put` is ignored and `err_cnt` = 1 (ERRCNT_EN). Grant once → `free` = 1 and the head becomes the second packet.
- Drop `put` after 2 bytes → no push, `out_req` stays 0, FSM back in IDLE, `err_cnt` increments. The next full packet is received intact.
- At count == 1, make the 4th-byte edge coincide with `out_grant` → count stays 1, `out_pkt` shows the new packet, and there is no loss or duplicate.
- Assert `rst_b` in the middle of a packet (after byte 2) → all state clears and `free` = 1 the next cycle; a subsequent packet completes correctly.
